instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_isa_pkg.sv | 47 ++++
 rtl/instr_fifo.sv | 56 +++++
 rtl/instr_encoder.sv | 112 +++++++++++
 tb/tb_instr_encoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset definitions: request mnemonic codes, major opcodes and R-type funct codes.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OpNop  = 5'd0,  OpAdd  = 5'd1,  OpSub  = 5'd2,  OpAnd  = 5'd3,  OpOr   = 5'd4,
    OpSlt  = 5'd5,  OpSltu = 5'd6,  OpAddi = 5'd7,  OpAndi = 5'd8,  OpOri  = 5'd9,
    OpLui  = 5'd10, OpLb   = 5'd11, OpLh   = 5'd12, OpLw   = 5'd13, OpSb   = 5'd14,
    OpSh   = 5'd15, OpSw   = 5'd16, OpMult = 5'd17, OpMultu = 5'd18, OpDiv = 5'd19,
    OpDivu = 5'd20, OpMfhi = 5'd21, OpMflo = 5'd22, OpMthi = 5'd23, OpMtlo = 5'd24,
    OpShl  = 5'd25, OpBeq  = 5'd26, OpBne  = 5'd27, OpJal  = 5'd28, OpJr   = 5'd29
  } op_e;

  localparam logic [5:0] OpcRtype = 6'b000000;
  localparam logic [5:0] OpcAddi  = 6'b001000;
  localparam logic [5:0] OpcAndi  = 6'b001100;
  localparam logic [5:0] OpcOri   = 6'b001101;
  localparam logic [5:0] OpcLui   = 6'b001111;
  localparam logic [5:0] OpcLb    = 6'b100000;
  localparam logic [5:0] OpcLh    = 6'b100001;
  localparam logic [5:0] OpcLw    = 6'b100011;
  localparam logic [5:0] OpcSb    = 6'b101000;
  localparam logic [5:0] OpcSh    = 6'b101001;
  localparam logic [5:0] OpcSw    = 6'b101011;
  localparam logic [5:0] OpcBeq   = 6'b000100;
  localparam logic [5:0] OpcBne   = 6'b000101;
  localparam logic [5:0] OpcJal   = 6'b000011;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSltu  = 6'b101011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnShl   = 6'b111000;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam logic [31:0] AddrBase = 32'h0000_3000;

endpackage

// File: rtl/instr_fifo.sv
// 4-entry FIFO holding {instr, addr}; head reads as zero while empty.
module instr_fifo #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [2:0]       level_o
);

  logic [Width-1:0] mem_q [4];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != 3'd4);
  assign do_pop  = pop_i && (count_q != 3'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q != 3'd0) ? mem_q[rd_ptr_q] : '0;
  assign level_o = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Encodes mnemonic requests into MIPS words, tagging each with its load address, via a 4-deep FIFO.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [2:0]  level
);

  logic [31:0] enc_word;
  logic        legal;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        accept, push;
  logic [63:0] head;

  function automatic logic [31:0] rword(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {OpcRtype, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] iword(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (req_op)
      OpNop:   enc_word = '0;
      OpAdd:   enc_word = rword(req_rs, req_rt, req_rd, FnAdd);
      OpSub:   enc_word = rword(req_rs, req_rt, req_rd, FnSub);
      OpAnd:   enc_word = rword(req_rs, req_rt, req_rd, FnAnd);
      OpOr:    enc_word = rword(req_rs, req_rt, req_rd, FnOr);
      OpSlt:   enc_word = rword(req_rs, req_rt, req_rd, FnSlt);
      OpSltu:  enc_word = rword(req_rs, req_rt, req_rd, FnSltu);
      OpMult:  enc_word = rword(req_rs, req_rt, 5'd0, FnMult);
      OpMultu: enc_word = rword(req_rs, req_rt, 5'd0, FnMultu);
      OpDiv:   enc_word = rword(req_rs, req_rt, 5'd0, FnDiv);
      OpDivu:  enc_word = rword(req_rs, req_rt, 5'd0, FnDivu);
      OpMfhi:  enc_word = rword(5'd0, 5'd0, req_rd, FnMfhi);
      OpMflo:  enc_word = rword(5'd0, 5'd0, req_rd, FnMflo);
      OpMthi:  enc_word = rword(req_rs, 5'd0, 5'd0, FnMthi);
      OpMtlo:  enc_word = rword(req_rs, 5'd0, 5'd0, FnMtlo);
      OpShl:   enc_word = rword(req_rs, req_rt, req_rd, FnShl);
      OpJr:    enc_word = rword(req_rs, 5'd0, 5'd0, FnJr);
      OpAddi:  enc_word = iword(OpcAddi, req_rs, req_rt, req_imm);
      OpAndi:  enc_word = iword(OpcAndi, req_rs, req_rt, req_imm);
      OpOri:   enc_word = iword(OpcOri, req_rs, req_rt, req_imm);
      OpLui:   enc_word = iword(OpcLui, 5'd0, req_rt, req_imm);
      OpLb:    enc_word = iword(OpcLb, req_rs, req_rt, req_imm);
      OpLh:    enc_word = iword(OpcLh, req_rs, req_rt, req_imm);
      OpLw:    enc_word = iword(OpcLw, req_rs, req_rt, req_imm);
      OpSb:    enc_word = iword(OpcSb, req_rs, req_rt, req_imm);
      OpSh:    enc_word = iword(OpcSh, req_rs, req_rt, req_imm);
      OpSw:    enc_word = iword(OpcSw, req_rs, req_rt, req_imm);
      OpBeq:   enc_word = iword(OpcBeq, req_rs, req_rt, req_imm);
      OpBne:   enc_word = iword(OpcBne, req_rs, req_rt, req_imm);
      OpJal:   enc_word = {OpcJal, req_target};
      default: legal = 1'b0;
    endcase
  end

  // Illegal ops are still accepted (handshake completes) but only raise the error pulse.
  assign req_ready = !reset && (level != 3'd4);
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal;
  assign addr_d    = push ? addr_q + 32'd4 : addr_q;
  assign err_d     = accept && !legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= AddrBase;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  instr_fifo #(
    .Width(64)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({enc_word, addr_q}),
    .pop_i   (out_valid && out_ready),
    .rdata_o (head),
    .level_o (level)
  );

  assign out_valid   = (level != 3'd0);
  assign out_instr   = head[63:32];
  assign out_addr    = head[31:0];
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder against a table-driven encoding/FIFO model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err_illegal;
  logic [2:0]  level;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_imm    (req_imm),
    .req_target (req_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_illegal(err_illegal),
    .level      (level)
  );

  // {opcode, funct, uses rs, uses rt, uses rd, uses imm, uses target}
  localparam logic [16:0] Tbl [30] = '{
    {6'h00, 6'h00, 5'b00000}, {6'h00, 6'h20, 5'b11100}, {6'h00, 6'h22, 5'b11100},
    {6'h00, 6'h24, 5'b11100}, {6'h00, 6'h25, 5'b11100}, {6'h00, 6'h2a, 5'b11100},
    {6'h00, 6'h2b, 5'b11100}, {6'h08, 6'h00, 5'b11010}, {6'h0c, 6'h00, 5'b11010},
    {6'h0d, 6'h00, 5'b11010}, {6'h0f, 6'h00, 5'b01010}, {6'h20, 6'h00, 5'b11010},
    {6'h21, 6'h00, 5'b11010}, {6'h23, 6'h00, 5'b11010}, {6'h28, 6'h00, 5'b11010},
    {6'h29, 6'h00, 5'b11010}, {6'h2b, 6'h00, 5'b11010}, {6'h00, 6'h18, 5'b11000},
    {6'h00, 6'h19, 5'b11000}, {6'h00, 6'h1a, 5'b11000}, {6'h00, 6'h1b, 5'b11000},
    {6'h00, 6'h10, 5'b00100}, {6'h00, 6'h12, 5'b00100}, {6'h00, 6'h11, 5'b10000},
    {6'h00, 6'h13, 5'b10000}, {6'h00, 6'h38, 5'b11100}, {6'h04, 6'h00, 5'b11010},
    {6'h05, 6'h00, 5'b11010}, {6'h03, 6'h00, 5'b00001}, {6'h00, 6'h08, 5'b10000}
  };

  logic [63:0] mq[$];
  logic [31:0] maddr = 32'h3000;
  logic        merr = 1'b0;

  function automatic logic [31:0] model_enc(int op, logic [4:0] rs, logic [4:0] rt,
                                            logic [4:0] rd, logic [15:0] imm, logic [25:0] tg);
    logic [16:0] e;
    logic [4:0]  frs, frt, frd;
    e   = Tbl[op];
    frs = e[4] ? rs : 5'd0;
    frt = e[3] ? rt : 5'd0;
    frd = e[2] ? rd : 5'd0;
    if (e[0]) return {e[16:11], tg};
    if (e[1]) return {e[16:11], frs, frt, imm};
    return {e[16:11], frs, frt, frd, 5'd0, e[10:5]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("level", {29'd0, level}, mq.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("req_ready", {31'd0, req_ready}, {31'd0, mq.size() != 4});
    chk("err_illegal", {31'd0, err_illegal}, {31'd0, merr});
    chk("out_instr", out_instr, mq.size() != 0 ? mq[0][63:32] : 32'd0);
    chk("out_addr", out_addr, mq.size() != 0 ? mq[0][31:0] : 32'd0);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(logic v, int op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                      logic [15:0] imm, logic [25:0] tg, logic ordy);
    logic acc;
    req_valid = v; req_op = op[4:0]; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tg; out_ready = ordy;
    @(negedge clk);
    check_model();
    acc = v && (mq.size() != 4);
    if (ordy && mq.size() != 0) void'(mq.pop_front());
    if (acc && op < 30) begin
      mq.push_back({model_enc(op, rs, rt, rd, imm, tg), maddr});
      maddr += 32'd4;
    end
    merr = acc && (op >= 30);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(logic ordy);
    step(1'b0, 0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, ordy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    maddr = 32'h3000;
    merr = 1'b0;
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_err", {31'd0, err_illegal}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ADD r3 = r1 + r2
    step(1'b1, 1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    chk("add_word", out_instr, 32'h0022_1820);
    chk("add_addr", out_addr, 32'h0000_3000);
    idle(1'b1);

    // ORI then LUI: addresses restart from the base after reset
    do_reset();
    step(1'b1, 9, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0, 1'b0);
    step(1'b1, 10, 5'd5, 5'd9, 5'd0, 16'hABCD, 26'h0, 1'b0);
    chk("ori_word", out_instr, 32'h3408_1234);
    chk("ori_addr", out_addr, 32'h0000_3000);
    idle(1'b1);
    chk("lui_word", out_instr, 32'h3C09_ABCD);
    chk("lui_addr", out_addr, 32'h0000_3004);
    idle(1'b1);

    // SHL and JAL
    step(1'b1, 25, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
    chk("shl_word", out_instr, 32'h0085_3038);
    step(1'b1, 28, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C03, 1'b1);
    chk("jal_word", out_instr, 32'h0C00_0C03);
    idle(1'b1);

    // Fill with out_ready low: 5th request must be refused, head held
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1, 5'd1, 5'd2, 5'(i), 16'h0, 26'h0, 1'b0);
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    chk("full_head", out_instr, 32'h0022_0020);
    idle(1'b0);
    chk("stall_head", out_instr, 32'h0022_0020);
    chk("stall_addr", out_addr, 32'h0000_3000);

    // Illegal op: pulse once, no enqueue, no address advance
    do_reset();
    step(1'b1, 7, 5'd1, 5'd1, 5'd0, 16'h0001, 26'h0, 1'b0);
    step(1'b1, 30, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    chk("ill_pulse", {31'd0, err_illegal}, 32'd1);
    chk("ill_level", {29'd0, level}, 32'd1);
    step(1'b1, 1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    chk("ill_pulse_end", {31'd0, err_illegal}, 32'd0);
    idle(1'b1);
    chk("ill_next_addr", out_addr, 32'h0000_3004);
    idle(1'b1);

    // Mid-stream reset at level 3
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 13, 5'd2, 5'(i), 5'd0, 16'h10, 26'h0, 1'b0);
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    do_reset();
    step(1'b1, 1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    chk("post_rst_addr", out_addr, 32'h0000_3000);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), 5'($urandom),
                5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
                ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
